// File: rtl/sort_pkg.sv
// Shared types and default sizes for the bitonic sorter output stage.
package sort_pkg;

  // Drain controller states: IDLE waits for a vector, DRAIN streams it out.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  localparam int WIDTH   = 8;
  localparam int INDEX   = 8;
  localparam int INDEX_W = 3;

endpackage

// File: rtl/sort_drain.sv
// sort_drain: buffers one sorted vector and streams it out one element per
// beat with index and last-beat flag. Back-to-back vectors are accepted on
// the final beat so the stream has no bubble.
// Build option: define SORT_DRAIN_DESC_EN to emit elements in descending
// order (highest buffer position first); ports are identical in both builds.
module sort_drain
  import sort_pkg::*;
#(
  parameter int width       = WIDTH,
  parameter int index       = INDEX,
  parameter int index_width = INDEX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [width-1:0]       in_data [0:index-1],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_data,
  output logic [index_width-1:0] out_idx,
  output logic                   out_last,
  output logic                   busy
);

`ifdef SORT_DRAIN_DESC_EN
  // Descending: start at the top of the buffer and count down to 0.
  localparam logic [index_width-1:0] START_CNT = index_width'(index - 1);
  localparam logic [index_width-1:0] LAST_CNT  = '0;
`else
  // Ascending: start at element 0 (smallest) and count up.
  localparam logic [index_width-1:0] START_CNT = '0;
  localparam logic [index_width-1:0] LAST_CNT  = index_width'(index - 1);
`endif

  drain_state_t           state_q, state_d;
  logic [index_width-1:0] cnt_q, cnt_d;
  logic [width-1:0]       buf_q [0:index-1];

  logic draining;
  logic is_last;
  logic beat;
  logic load;
  logic [index_width-1:0] cnt_adv;

  // Handshake decode; in_ready depends on out_ready combinationally so a new
  // vector can be taken on the same cycle the last element leaves.
  always_comb begin
    draining  = (state_q == DRAIN);
    is_last   = draining && (cnt_q == LAST_CNT);
    beat      = draining && out_ready;
    in_ready  = (state_q == IDLE) || (is_last && out_ready);
    load      = in_valid && in_ready;
`ifdef SORT_DRAIN_DESC_EN
    cnt_adv   = cnt_q - 1'b1;
`else
    cnt_adv   = cnt_q + 1'b1;
`endif
  end

  // Next-state and counter update: load wins, otherwise advance on a beat,
  // returning to IDLE after the last beat when nothing new is offered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = DRAIN;
      cnt_d   = START_CNT;
    end else if (beat) begin
      if (is_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_adv;
      end
    end
  end

  // Controller state and element counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Vector buffer: written only when a new vector is accepted, so it never
  // changes mid-drain.
  for (genvar gi = 0; gi < index; gi++) begin : g_buf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf_q[gi] <= '0;
      end else if (load) begin
        buf_q[gi] <= in_data[gi];
      end
    end
  end

  // Outputs come straight from registers; nothing from in_data reaches them
  // in the same cycle.
  always_comb begin
    out_valid = draining;
    out_data  = buf_q[cnt_q];
    out_idx   = cnt_q;
    out_last  = is_last;
    busy      = draining;
  end

endmodule

// File: doc/sort_drain.md
Name: sort_drain

Overview:
- Output end of the bitonic sorter pipeline.
- Accepts one fully sorted vector of `index` elements from the final sort stage through a valid/ready handshake, buffers it, and streams it out one element per beat.
- The stream uses a valid/ready handshake with element index and last-beat flag.
- Sustains full throughput: one vector every `index` cycles when the downstream never stalls.

Parameters:
- width, 8, bit width of one element
- index, 8, elements per vector; power of two, at least 2
- index_width, 3, log2(index); width of the element counter and out_idx

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sorted vector on in_data is valid
- in_ready  output  1  block can accept a vector this cycle
- in_data  input  width x [0:index-1]  sorted vector, unpacked array, element 0 smallest
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  downstream accepts the element this cycle
- out_data  output  width  current element
- out_idx  output  index_width  buffer position of the current element
- out_last  output  1  current element is the final beat of the vector
- busy  output  1  a vector is held in the buffer, i.e. state is DRAIN

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0.
  - Buffer cleared to 0.
  - out_valid = 0, out_last = 0, busy = 0, out_data = 0, out_idx = 0.
  - in_ready = 1 once reset deasserts.
- States: IDLE, DRAIN.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: capture all index elements into the buffer, set cnt = 0, go to DRAIN.
  - in_data is ignored while in_valid is low.
- DRAIN:
  - out_valid = 1.
  - out_data = buf[cnt] and out_idx = cnt, both driven from registers with no combinational path from in_data.
  - out_last = 1 when cnt == index-1.
  - Beat transfers when out_valid && out_ready; then cnt increments.
  - Without out_ready: out_data, out_idx and out_last hold stable and cnt does not advance.
- End of vector:
  - in_ready = IDLE || (DRAIN && out_last && out_ready). This is a combinational path from out_ready to in_ready and is intended.
  - On the last beat with in_valid high: capture the new vector, cnt = 0, stay in DRAIN. No bubble.
  - On the last beat with in_valid low: go to IDLE, cnt = 0.
- Latency: first element appears on out_data one cycle after the input handshake. A vector drains in exactly index cycles with out_ready held high.
- cnt is index_width bits and wraps naturally from index-1 to 0.
- The buffer is never written mid-drain. in_valid during a non-final DRAIN beat sees in_ready = 0 and is held off by the upstream.
- Reset mid-drain: the remaining elements are discarded, with no partial beat afterwards.
- Elements are passed through unmodified; no arithmetic is performed.

Optional Feature:
- Macro: SORT_DRAIN_DESC_EN.
- Defined: elements emit in descending order.
  - cnt starts at index-1 and decrements.
  - out_idx = cnt.
  - out_last = 1 when cnt == 0.
  - in_ready and back-to-back rules apply with this last-beat condition.
- Undefined: ascending order as above.
- Port list is identical in both builds.

Decomposition:
- sort_pkg holds:
  - typedef enum logic {IDLE, DRAIN} drain_state_t.
  - Shared default localparams WIDTH = 8, INDEX = 8, INDEX_W = 3.
- No sub-module is required. The buffer, counter and FSM live in sort_drain, since a single counter with load/advance is too thin to split out.

Test Plan:
- Reset then in_data = {3,7,9,12,20,33,41,255}, in_valid for 1 cycle, out_ready = 1 -> out_data 3,7,9,12,20,33,41,255 on 8 consecutive cycles starting 1 cycle after the handshake; out_idx 0..7; out_last only on 255; in_ready low on beats 0-6.
- Same vector with out_ready toggling 1,0,0,1,... -> no duplicated or dropped elements; out_data stable while stalled.
- Two vectors back-to-back, the second presented on the last beat of the first -> 16 consecutive valid beats with no bubble.
- rst_n pulsed low on the 4th beat -> out_valid drops to 0 asynchronously; after release, in_ready = 1 and the next vector starts at element 0.
- in_valid held high with a changing in_data during DRAIN beats 0-6 -> buffer unchanged; only the vector present on the last beat is captured.
- With SORT_DRAIN_DESC_EN defined and {1,2,...,8} -> output 8,7,...,1; out_idx 7..0; out_last on value 1.
